// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// funct fields, aluop codes and the 3-bit ALU control bus.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOP = 3'b011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder: maps the FSM aluop plus the R-type funct field onto
// the 3-bit ALU control bus.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_NOP;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_NOP;
        endcase
      end
      default: alu_control = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: Moore-decoded mux selects
// and write enables, branch resolution on the ALU zero flag, retired counter.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic [2:0]       alu_control,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       memwrite_s;
  logic       retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d   = S_DECODE;
        irwrite_s = 1'b1;
        alusrcb   = 2'b01;
        pcwrite   = 1'b1;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        state_d = S_MEMWB;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
        retire     = 1'b1;
      end
      S_RTYPEEX: begin
        state_d = S_RTYPEWB;
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
        retire     = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        retire  = 1'b1;
      end
      S_ADDIEX: begin
        state_d = S_ADDIWB;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
        retire     = 1'b1;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural write enables are held off while reset is asserted.
  assign irwrite  = irwrite_s & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign state_o  = state_q;

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: state sequences, per-state outputs,
// branch resolution, mid-instruction reset and retired-counter wrap.
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             iord;
  logic             memwrite;
  logic             irwrite;
  logic             regdst;
  logic             memtoreg;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic             pcen;
  logic [2:0]       alu_control;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] retired;

  int errors = 0;
  int checks = 0;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .iord        (iord),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .regdst      (regdst),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .pcsrc       (pcsrc),
    .pcen        (pcen),
    .alu_control (alu_control),
    .state_o     (state_o),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_lw();
    reset = 1'b1; op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({irwrite, pcen, regwrite, memwrite} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_enables cyc=%0d got=%b want=0000", i, {irwrite, pcen, regwrite, memwrite});
      end
      checks++;
      if (retired !== 4'd0 || state_o !== 4'd0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d retired=%0d state=%0d want 0/0", i, retired, state_o);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || irwrite !== 1'b1 || pcen !== 1'b1 || alusrcb !== 2'b01) begin
      errors++;
      $display("FAIL fetch_after_reset state=%0d irwrite=%b pcen=%b alusrcb=%b want 0/1/1/01",
               state_o, irwrite, pcen, alusrcb);
    end
    step();
    checks++;
    if (state_o !== 4'd1 || alusrcb !== 2'b11 || pcen !== 1'b0) begin
      errors++;
      $display("FAIL lw_decode state=%0d alusrcb=%b pcen=%b want 1/11/0", state_o, alusrcb, pcen);
    end
    step();
    checks++;
    if (state_o !== 4'd2 || alusrca !== 1'b1 || alusrcb !== 2'b10) begin
      errors++;
      $display("FAIL lw_memadr state=%0d alusrca=%b alusrcb=%b want 2/1/10", state_o, alusrca, alusrcb);
    end
    step();
    checks++;
    if (state_o !== 4'd3 || iord !== 1'b1) begin
      errors++;
      $display("FAIL lw_memrd state=%0d iord=%b want 3/1", state_o, iord);
    end
    step();
    checks++;
    if (state_o !== 4'd4 || regwrite !== 1'b1 || memtoreg !== 1'b1 || retired !== 4'd0) begin
      errors++;
      $display("FAIL lw_memwb state=%0d regwrite=%b memtoreg=%b retired=%0d want 4/1/1/0",
               state_o, regwrite, memtoreg, retired);
    end
    step();
    checks++;
    if (state_o !== 4'd0 || retired !== 4'd1) begin
      errors++;
      $display("FAIL lw_retire state=%0d retired=%0d want 0/1", state_o, retired);
    end
  endtask

  task automatic test_rtype();
    op = 6'b000000; funct = 6'b101010;
    step();
    step();
    checks++;
    if (state_o !== 4'd6 || alu_control !== 3'b111 || alusrca !== 1'b1 || alusrcb !== 2'b00) begin
      errors++;
      $display("FAIL rtype_ex state=%0d alu_control=%b alusrca=%b alusrcb=%b want 6/111/1/00",
               state_o, alu_control, alusrca, alusrcb);
    end
    funct = 6'b100100;
    #1;
    checks++;
    if (alu_control !== 3'b000) begin
      errors++;
      $display("FAIL rtype_and alu_control=%b want 000", alu_control);
    end
    funct = 6'b111111;
    #1;
    checks++;
    if (alu_control !== 3'b011) begin
      errors++;
      $display("FAIL rtype_unknown alu_control=%b want 011", alu_control);
    end
    funct = 6'b101010;
    step();
    checks++;
    if (state_o !== 4'd7 || regdst !== 1'b1 || regwrite !== 1'b1) begin
      errors++;
      $display("FAIL rtype_wb state=%0d regdst=%b regwrite=%b want 7/1/1", state_o, regdst, regwrite);
    end
    step();
    checks++;
    if (state_o !== 4'd0 || retired !== 4'd2) begin
      errors++;
      $display("FAIL rtype_retire state=%0d retired=%0d want 0/2", state_o, retired);
    end
  endtask

  task automatic test_beq();
    op = 6'b000100; zero = 1'b1;
    step();
    step();
    checks++;
    if (state_o !== 4'd8 || pcen !== 1'b1 || pcsrc !== 2'b01 || alu_control !== 3'b110) begin
      errors++;
      $display("FAIL beq_taken state=%0d pcen=%b pcsrc=%b alu_control=%b want 8/1/01/110",
               state_o, pcen, pcsrc, alu_control);
    end
    step();
    checks++;
    if (state_o !== 4'd0 || retired !== 4'd3) begin
      errors++;
      $display("FAIL beq_taken_retire state=%0d retired=%0d want 0/3", state_o, retired);
    end
    zero = 1'b0;
    step();
    step();
    checks++;
    if (state_o !== 4'd8 || pcen !== 1'b0 || pcsrc !== 2'b01) begin
      errors++;
      $display("FAIL beq_not_taken state=%0d pcen=%b pcsrc=%b want 8/0/01", state_o, pcen, pcsrc);
    end
    step();
    checks++;
    if (state_o !== 4'd0 || retired !== 4'd4) begin
      errors++;
      $display("FAIL beq_nt_retire state=%0d retired=%0d want 0/4", state_o, retired);
    end
  endtask

  task automatic test_jump_nop();
    op = 6'b000010; zero = 1'b0;
    step();
    step();
    checks++;
    if (state_o !== 4'd11 || pcsrc !== 2'b10 || pcen !== 1'b1) begin
      errors++;
      $display("FAIL j_ex state=%0d pcsrc=%b pcen=%b want 11/10/1", state_o, pcsrc, pcen);
    end
    step();
    checks++;
    if (state_o !== 4'd0 || retired !== 4'd5) begin
      errors++;
      $display("FAIL j_retire state=%0d retired=%0d want 0/5", state_o, retired);
    end
    op = 6'b111111;
    step();
    checks++;
    if (state_o !== 4'd1) begin
      errors++;
      $display("FAIL nop_decode state=%0d want 1", state_o);
    end
    step();
    checks++;
    if (state_o !== 4'd0 || retired !== 4'd5) begin
      errors++;
      $display("FAIL nop_no_count state=%0d retired=%0d want 0/5", state_o, retired);
    end
  endtask

  task automatic test_reset_mid_sw();
    op = 6'b101011;
    step();
    step();
    step();
    checks++;
    if (state_o !== 4'd5 || memwrite !== 1'b1 || iord !== 1'b1) begin
      errors++;
      $display("FAIL sw_memwr state=%0d memwrite=%b iord=%b want 5/1/1", state_o, memwrite, iord);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (memwrite !== 1'b0 || iord !== 1'b1) begin
      errors++;
      $display("FAIL sw_reset_gate memwrite=%b iord=%b want 0/1", memwrite, iord);
    end
    step();
    checks++;
    if (state_o !== 4'd0 || retired !== 4'd0) begin
      errors++;
      $display("FAIL sw_reset_abandon state=%0d retired=%0d want 0/0", state_o, retired);
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    op = 6'b000010;
    for (int i = 0; i < 15; i++) begin
      step();
      step();
      step();
    end
    checks++;
    if (state_o !== 4'd0 || retired !== 4'd15) begin
      errors++;
      $display("FAIL wrap_pre state=%0d retired=%0d want 0/15", state_o, retired);
    end
    op = 6'b001000;
    step();
    step();
    checks++;
    if (state_o !== 4'd9 || alusrca !== 1'b1 || alusrcb !== 2'b10 || alu_control !== 3'b010) begin
      errors++;
      $display("FAIL addi_ex state=%0d alusrca=%b alusrcb=%b alu_control=%b want 9/1/10/010",
               state_o, alusrca, alusrcb, alu_control);
    end
    step();
    checks++;
    if (state_o !== 4'd10 || regwrite !== 1'b1 || regdst !== 1'b0 || memtoreg !== 1'b0) begin
      errors++;
      $display("FAIL addi_wb state=%0d regwrite=%b regdst=%b memtoreg=%b want 10/1/0/0",
               state_o, regwrite, regdst, memtoreg);
    end
    step();
    checks++;
    if (state_o !== 4'd0 || retired !== 4'd0) begin
      errors++;
      $display("FAIL wrap state=%0d retired=%0d want 0/0", state_o, retired);
    end
  endtask

  initial begin
    test_reset_lw();
    test_rtype();
    test_beq();
    test_jump_nop();
    test_reset_mid_sw();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
